// File: rtl/itype_seq_ctrl.sv
// Multi-cycle sequencer for the I-type ALU datapath: fetch over req/ack, decode the
// opcode into an ALU select, then pulse the register-file write once per instruction.
module itype_seq_ctrl #(
  parameter int unsigned N         = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_INSTR = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [N-1:0]      imem_data,
  output logic [N-1:0]      instruction,
  output logic [3:0]        ALU_OP,
  output logic              RegWrite,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [15:0]       retired
);

  localparam logic [ADDR_W-1:0] BasePc   = ADDR_W'(BASE_ADDR);
  localparam logic [15:0]       MaxCount = 16'(MAX_INSTR);

  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpSlti = 6'b001010;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StDone
  } state_e;

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic [N-1:0]      r_instr, w_instr_next;
  logic [3:0]        r_alu_op, w_alu_op_next;
  logic              r_illegal, w_illegal_next;
  logic [15:0]       r_retired, w_retired_next;
  logic [15:0]       w_retired_inc;
  logic [5:0]        w_opcode;

  assign w_opcode      = r_instr[31:26];
  assign w_retired_inc = r_retired + 16'd1;

  // State and datapath-facing registers; reset aborts any fetch or write immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_pc      <= BasePc;
      r_instr   <= '0;
      r_alu_op  <= 4'b0010;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_instr   <= w_instr_next;
      r_alu_op  <= w_alu_op_next;
      r_illegal <= w_illegal_next;
      r_retired <= w_retired_next;
    end
  end

  // Next-state logic: one instruction at a time until halt, illegal opcode or retire limit.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_instr_next   = r_instr;
    w_alu_op_next  = r_alu_op;
    w_illegal_next = r_illegal;
    w_retired_next = r_retired;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_next   = StFetch;
          w_pc_next      = BasePc;
          w_illegal_next = 1'b0;
          w_retired_next = '0;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          w_instr_next = imem_data;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        if (r_instr == '0) begin
          // All-zero word is the halt marker, not an illegal opcode.
          w_state_next = StDone;
        end else begin
          w_state_next = StExecute;
          case (w_opcode)
            OpAddi:  w_alu_op_next = 4'b0010;
            OpAndi:  w_alu_op_next = 4'b0000;
            OpOri:   w_alu_op_next = 4'b0001;
            OpSlti:  w_alu_op_next = 4'b0111;
            default: begin
              w_illegal_next = 1'b1;
              w_state_next   = StDone;
            end
          endcase
        end
      end
      StExecute: begin
        w_state_next = StWriteback;
      end
      StWriteback: begin
        w_retired_next = w_retired_inc;
        w_pc_next      = r_pc + ADDR_W'(4);
        w_state_next   = (w_retired_inc == MaxCount) ? StDone : StFetch;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    imem_req = (r_state == StFetch);
    RegWrite = (r_state == StWriteback) && (r_instr[20:16] != 5'd0);
    busy     = (r_state != StIdle) && (r_state != StDone);
    done     = (r_state == StDone);
  end

  assign imem_addr   = r_pc;
  assign instruction = r_instr;
  assign ALU_OP      = r_alu_op;
  assign illegal     = r_illegal;
  assign retired     = r_retired;

endmodule

// File: tb/tb_itype_seq_ctrl.sv
// Directed bench for itype_seq_ctrl: memory model with per-word ack delay, scoreboard of
// expected write-backs, and a second instance with a retire limit of 2.
module tb_itype_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic [3:0]  alu_op;
  logic        reg_write;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [15:0] retired;

  logic        start2;
  logic        req2;
  logic [15:0] addr2;
  logic        ack2;
  logic [31:0] data2;
  logic [31:0] instr2;
  logic [3:0]  alu_op2;
  logic        reg_write2;
  logic        busy2;
  logic        done2;
  logic        illegal2;
  logic [15:0] retired2;

  logic [31:0] mem [64];
  int unsigned dly [64];
  int unsigned wait_cnt = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int fetch_idx;
  int cyc;
  int wb_cycle;
  int pulses2;

  always #5 clk = ~clk;

  // Instruction memory: ack once the word's programmed wait has elapsed.
  assign imem_ack  = imem_req && (wait_cnt == dly[imem_addr[7:2]]);
  assign imem_data = mem[imem_addr[7:2]];
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  assign ack2  = req2;
  assign data2 = mem[addr2[7:2]];

  itype_seq_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instruction (instruction),
    .ALU_OP      (alu_op),
    .RegWrite    (reg_write),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .retired     (retired)
  );

  itype_seq_ctrl #(.MAX_INSTR(2)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .start       (start2),
    .imem_req    (req2),
    .imem_addr   (addr2),
    .imem_ack    (ack2),
    .imem_data   (data2),
    .instruction (instr2),
    .ALU_OP      (alu_op2),
    .RegWrite    (reg_write2),
    .busy        (busy2),
    .done        (done2),
    .illegal     (illegal2),
    .retired     (retired2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle, sampled at the falling edge: scoreboard write-backs and fetch addresses.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (reg_write) begin
      if (sb.size() == 0) begin
        chk("spurious RegWrite", {31'd0, reg_write}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb ALU_OP", {28'd0, alu_op}, {28'd0, e.op});
        chk("wb instruction", instruction, e.ins);
        if (wb_cycle == 0) wb_cycle = cyc;
      end
    end
    if (imem_req) begin
      chk("imem_addr", {16'd0, imem_addr}, 32'(4 * fetch_idx));
      if (imem_ack) fetch_idx++;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start     = 1'b1;
    fetch_idx = 0;
    cyc       = 0;
    wb_cycle  = 0;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done();
    int k = 0;
    while (!done && k < 200) begin
      step();
      k++;
    end
    chk("done reached", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, " RegWrite"}, {31'd0, reg_write}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " illegal"}, {31'd0, illegal}, 32'd0);
    chk({tag, " retired"}, {16'd0, retired}, 32'd0);
    chk({tag, " ALU_OP"}, {28'd0, alu_op}, 32'd2);
    chk({tag, " instruction"}, instruction, 32'd0);
    chk({tag, " imem_addr"}, {16'd0, imem_addr}, 32'd0);
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'd0;
      dly[i] = 0;
    end
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single addi, zero wait: write-back in the 4th cycle counting FETCH as the 1st.
    mem[0] = 32'h2010_0014;
    mem[1] = 32'h0000_0000;
    sb.push_back('{op: 4'b0010, ins: 32'h2010_0014});
    do_start();
    chk("fetch busy", {31'd0, busy}, 32'd1);
    run_to_done();
    chk("t1 wb cycle", 32'(wb_cycle), 32'd4);
    chk("t1 retired", {16'd0, retired}, 32'd1);
    chk("t1 illegal", {31'd0, illegal}, 32'd0);
    chk("t1 fetches", 32'(fetch_idx), 32'd2);

    // Three-instruction program with a 5-cycle stall on the second fetch.
    mem[0] = 32'h2051_003F;
    mem[1] = 32'h30D3_0000;
    mem[2] = 32'h3514_0000;
    mem[3] = 32'h0000_0000;
    dly[1] = 5;
    sb.push_back('{op: 4'b0010, ins: 32'h2051_003F});
    sb.push_back('{op: 4'b0000, ins: 32'h30D3_0000});
    sb.push_back('{op: 4'b0001, ins: 32'h3514_0000});
    do_start();
    chk("restart clears done", {31'd0, done}, 32'd0);
    run_to_done();
    dly[1] = 0;
    chk("t2 retired", {16'd0, retired}, 32'd3);
    chk("t2 illegal", {31'd0, illegal}, 32'd0);
    chk("t2 ALU_OP held", {28'd0, alu_op}, 32'd1);
    chk("t2 sb drained", 32'(sb.size()), 32'd0);
    chk("t2 busy in done", {31'd0, busy}, 32'd0);

    // Illegal opcode ends the run without a write; restart clears the flag.
    mem[0] = 32'hFC00_0000;
    do_start();
    run_to_done();
    chk("t3 illegal", {31'd0, illegal}, 32'd1);
    chk("t3 retired", {16'd0, retired}, 32'd0);
    step();
    chk("t3 illegal sticky", {31'd0, illegal}, 32'd1);
    chk("t3 pc held", {16'd0, imem_addr}, 32'd0);
    mem[0] = 32'h0000_0000;
    do_start();
    chk("t3 illegal cleared", {31'd0, illegal}, 32'd0);
    chk("t3 refetch req", {31'd0, imem_req}, 32'd1);
    run_to_done();

    // Write to R0 is suppressed but retires.
    mem[0] = 32'h2020_0005;
    mem[1] = 32'h0000_0000;
    do_start();
    run_to_done();
    chk("t4 retired", {16'd0, retired}, 32'd1);
    chk("t4 illegal", {31'd0, illegal}, 32'd0);

    // Retire limit of 2 with no halt word in memory.
    mem[0] = 32'h2010_0014;
    mem[1] = 32'h2011_0001;
    mem[2] = 32'h2012_0002;
    mem[3] = 32'h2013_0003;
    pulses2 = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 100 && !done2; k++) begin
      if (reg_write2) pulses2++;
      @(negedge clk);
    end
    chk("t5 done", {31'd0, done2}, 32'd1);
    chk("t5 pulses", 32'(pulses2), 32'd2);
    chk("t5 retired", {16'd0, retired2}, 32'd2);
    chk("t5 imem_addr", {16'd0, addr2}, 32'd8);

    // Reset during WRITEBACK drops RegWrite immediately; then a clean restart.
    mem[0] = 32'h2010_0014;
    mem[1] = 32'h0000_0000;
    sb.push_back('{op: 4'b0010, ins: 32'h2010_0014});
    sb.push_back('{op: 4'b0010, ins: 32'h2010_0014});
    do_start();
    for (int k = 0; k < 50 && wb_cycle == 0; k++) step();
    chk("t6 reached wb", {31'd0, reg_write}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk_reset_outputs("t6 mid-wb reset");
    @(negedge clk);
    rst = 1'b1;
    do_start();
    run_to_done();
    chk("t6 retired", {16'd0, retired}, 32'd1);
    chk("t6 sb drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
